// File: rtl/mcac_cu_pkg.sv
// Shared definitions for the ADPCM control unit: FSM encoding of the
// FMULT+ACCUM sequencer, default watchdog length and a width helper.
package mcac_cu_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int DEFAULT_NREQ    = 4;
    localparam int DEFAULT_TIMEOUT = 32;

    // Smallest w with 2**w >= value; usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fa_arbiter_if.sv
// Requester / datapath handshake bundle of the FMULT+ACCUM arbiter.
// The master side is the arbiter, the slave side is requesters plus datapath.
interface fa_arbiter_if
    import mcac_cu_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ
);

    localparam int SW = clog2(NREQ);

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [SW-1:0]   sel;
    logic            fa_start;
    logic            fa_done;
    logic [NREQ-1:0] req_done;
    logic            busy;
    logic            err_timeout;
    logic [SW-1:0]   err_id;
    logic            err_clr;

    modport master (
        input  req,
        input  fa_done,
        input  err_clr,
        output gnt,
        output sel,
        output fa_start,
        output req_done,
        output busy,
        output err_timeout,
        output err_id
    );

    modport slave (
        output req,
        output fa_done,
        output err_clr,
        input  gnt,
        input  sel,
        input  fa_start,
        input  req_done,
        input  busy,
        input  err_timeout,
        input  err_id
    );

endinterface

// File: rtl/fa_arbiter_rr_pick.sv
// Combinational round-robin picker: searches req starting one past 'last',
// wrapping modulo NREQ, and returns the first requester found.
module rr_pick
    import mcac_cu_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    localparam int SW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [SW-1:0]   last,
    output logic [SW-1:0]   winner,
    output logic            valid
);

    function automatic logic [SW-1:0] wrap_idx(input logic [SW-1:0] base, input int offs);
        int sum;
        sum = (int'(base) + offs) % NREQ;
        return SW'(sum);
    endfunction

    // Scan from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = NREQ; i >= 1; i--) begin
            winner = req[wrap_idx(last, i)] ? wrap_idx(last, i) : winner;
            valid  = valid | req[wrap_idx(last, i)];
        end
    end

endmodule

// File: rtl/fa_arbiter.sv
// Round-robin arbiter and sequencer for the shared FMULT+ACCUM datapath:
// grants one requester, pulses fa_start, waits for fa_done's rising edge.
module fa_arbiter
    import mcac_cu_pkg::*;
#(
    parameter int NREQ    = DEFAULT_NREQ,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic         clk,
    input  logic         reset,
    fa_arbiter_if.master bus
);

    localparam int SW = clog2(NREQ);
    localparam int CW = clog2(TIMEOUT + 1);

    localparam logic [NREQ-1:0] GNT_LSB  = NREQ'(32'd1);
    localparam logic [SW-1:0]   LAST_RST = SW'(NREQ - 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(32'd1);

    logic [1:0]      state_r;
    logic [1:0]      state_nx_s;
    logic [NREQ-1:0] gnt_r;
    logic [NREQ-1:0] gnt_nx_s;
    logic [SW-1:0]   sel_r;
    logic [SW-1:0]   sel_nx_s;
    logic [SW-1:0]   last_r;
    logic [SW-1:0]   last_nx_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_nx_s;
    logic            fa_done_d_r;
    logic            done_rise_s;
    logic            err_set_s;
    logic            err_timeout_r;
    logic [SW-1:0]   err_id_r;
    logic [SW-1:0]   pick_idx_s;
    logic            pick_valid_s;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req    (bus.req),
        .last   (last_r),
        .winner (pick_idx_s),
        .valid  (pick_valid_s)
    );

    // Only a rising edge counts, so a done level left high from before START is ignored.
    assign done_rise_s = bus.fa_done & ~fa_done_d_r;

    // Next-state and datapath-register decode of the sequencer.
    always_comb begin
        state_nx_s = state_r;
        gnt_nx_s   = gnt_r;
        sel_nx_s   = sel_r;
        last_nx_s  = last_r;
        cnt_nx_s   = cnt_r;
        err_set_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_nx_s = ST_START;
                    sel_nx_s   = pick_idx_s;
                    gnt_nx_s   = GNT_LSB << pick_idx_s;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_START: begin
                cnt_nx_s   = '0;
                state_nx_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_rise_s) begin
                    state_nx_s = ST_DONE;
                end else if (cnt_r == CNT_LAST) begin
                    // Abort: rotate priority past the stuck requester as if it had been served.
                    state_nx_s = ST_IDLE;
                    err_set_s  = 1'b1;
                    last_nx_s  = sel_r;
                    gnt_nx_s   = '0;
                end else begin
                    cnt_nx_s = cnt_r + CNT_ONE;
                end
            end
            ST_DONE: begin
                last_nx_s  = sel_r;
                gnt_nx_s   = '0;
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
                gnt_nx_s   = '0;
            end
        endcase
    end

    // Sequencer state, grant, priority pointer, watchdog counter and done-edge history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            gnt_r       <= '0;
            sel_r       <= '0;
            last_r      <= LAST_RST;
            cnt_r       <= '0;
            fa_done_d_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            gnt_r       <= gnt_nx_s;
            sel_r       <= sel_nx_s;
            last_r      <= last_nx_s;
            cnt_r       <= cnt_nx_s;
            fa_done_d_r <= bus.fa_done;
        end
    end

    // Sticky watchdog error; a new timeout takes precedence over a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_timeout_r <= 1'b0;
            err_id_r      <= '0;
        end else if (err_set_s) begin
            err_timeout_r <= 1'b1;
            err_id_r      <= sel_r;
        end else if (bus.err_clr) begin
            err_timeout_r <= 1'b0;
        end
    end

    assign bus.gnt         = gnt_r;
    assign bus.sel         = sel_r;
    assign bus.fa_start    = (state_r == ST_START);
    assign bus.req_done    = (state_r == ST_DONE) ? (GNT_LSB << sel_r) : '0;
    assign bus.busy        = (state_r != ST_IDLE);
    assign bus.err_timeout = err_timeout_r;
    assign bus.err_id      = err_id_r;

endmodule
